// File: rtl/fp_pkg.sv
// fp_pkg: FSM state encoding, result kinds and derived width helpers for the serial FP adder.
package fp_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SWAP  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_NORM  = 3'd4;
  localparam logic [2:0] S_PACK  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;
  function automatic int word_w(input int e, input int m);
    return 1 + e + m;
  endfunction
  // Working mantissa: hidden bit plus one carry bit above the stored fraction.
  function automatic int mant_w(input int m);
    return m + 2;
  endfunction
  function automatic int exp_ones(input int e);
    return (1 << e) - 1;
  endfunction
endpackage

// File: rtl/fp_norm_step.sv
// fp_norm_step: one normalisation step (carry right-shift or single left-shift) with exponent update.
module fp_norm_step
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W+1:0] mant,
  input  logic [EXP_W-1:0] ex,
  output logic [MAN_W+1:0] mant_o,
  output logic [EXP_W-1:0] ex_o,
  output logic             fin,
  output logic             ovf,
  output logic             unf
);
  localparam int MW = mant_w(MAN_W);
  localparam logic [EXP_W-1:0] ONES = EXP_W'(exp_ones(EXP_W));
  logic carry, norm;
  always_comb begin
    carry  = mant[MW-1];
    norm   = mant[MW-2];
    fin    = carry | norm;
    mant_o = carry ? mant >> 1 : norm ? mant : mant << 1;
    ex_o   = carry ? ex + 1'b1 : norm ? ex : ex - 1'b1;
    ovf    = carry && (ex + 1'b1) == ONES;
    unf    = !fin && ex <= EXP_W'(1);
  end
endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle truncating floating-point add/subtract with serial operand load and readout.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ser_in,
  input  logic                   ld_a,
  input  logic                   ld_b,
  input  logic                   op,
  input  logic                   start,
  input  logic                   shift_res,
  output logic                   busy,
  output logic                   done,
  output logic                   ser_out,
  output logic [EXP_W+MAN_W:0]   result
);
  localparam int W  = word_w(EXP_W, MAN_W);
  localparam int MW = mant_w(MAN_W);
  localparam logic [EXP_W-1:0] ONES = EXP_W'(exp_ones(EXP_W));
  logic [2:0] state;
  logic [W-1:0] a, b, pk;
  logic op_r, sign, sub, sa, sb, a_big, fin, ovf, unf;
  logic [EXP_W-1:0] ex, diff, ea, eb, ne;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0] big_m, small_m, ma, mb, sum, nm;
  kind_t kind;
  assign busy    = state != S_IDLE && state != S_DONE;
  assign done    = state == S_DONE;
  assign ser_out = result[W-1];
  always_comb begin
    sa    = a[W-1];
    ea    = a[W-2 -: EXP_W];
    fa    = a[MAN_W-1:0];
    sb    = b[W-1] ^ op_r;
    eb    = b[W-2 -: EXP_W];
    fb    = b[MAN_W-1:0];
    ma    = ea == '0 ? '0 : {2'b01, fa};
    mb    = eb == '0 ? '0 : {2'b01, fb};
    a_big = a[W-2:0] >= b[W-2:0];
    sum   = sub ? big_m - small_m : big_m + small_m;
    pk    = kind == K_NAN  ? {1'b0, ONES, 1'b1, {(MAN_W-1){1'b0}}} :
            kind == K_INF  ? {sign, ONES, {MAN_W{1'b0}}} :
            kind == K_ZERO ? '0 : {sign, ex, big_m[MAN_W-1:0]};
  end
  fp_norm_step #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm (
    .mant(big_m), .ex(ex), .mant_o(nm), .ex_o(ne), .fin(fin), .ovf(ovf), .unf(unf)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      a       <= '0;
      b       <= '0;
      result  <= '0;
      op_r    <= 1'b0;
      sign    <= 1'b0;
      sub     <= 1'b0;
      ex      <= '0;
      diff    <= '0;
      big_m   <= '0;
      small_m <= '0;
      kind    <= K_NUM;
    end else begin
      if (!busy && ld_a) a <= {a[W-2:0], ser_in};
      if (!busy && ld_b) b <= {b[W-2:0], ser_in};
      if (!busy && shift_res) result <= {result[W-2:0], 1'b0};
      case (state)
        S_IDLE: if (start) begin
          op_r  <= op;
          state <= S_SWAP;
        end
        S_SWAP: if (ea == ONES || eb == ONES) begin
          kind  <= K_NAN;
          state <= S_PACK;
        end else begin
          kind    <= K_NUM;
          sign    <= a_big ? sa : sb;
          sub     <= sa ^ sb;
          ex      <= a_big ? ea : eb;
          big_m   <= a_big ? ma : mb;
          small_m <= a_big ? mb : ma;
          diff    <= a_big ? ea - eb : eb - ea;
          state   <= S_ALIGN;
        end
        S_ALIGN: if (diff == '0) state <= S_ADD;
        else if (int'(diff) > MAN_W + 1) begin
          small_m <= '0;
          diff    <= '0;
          state   <= S_ADD;
        end else begin
          small_m <= small_m >> 1;
          diff    <= diff - 1'b1;
          if (diff == EXP_W'(1)) state <= S_ADD;
        end
        S_ADD: if (sum == '0) begin
          kind  <= K_ZERO;
          state <= S_PACK;
        end else begin
          big_m <= sum;
          state <= S_NORM;
        end
        S_NORM: if (ovf) begin
          kind  <= K_INF;
          state <= S_PACK;
        end else if (unf) begin
          kind  <= K_ZERO;
          state <= S_PACK;
        end else begin
          big_m <= nm;
          ex    <= ne;
          if (fin) state <= S_PACK;
        end
        S_PACK: begin
          result <= pk;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
